// File: rtl/rr_arb_defs_pkg.sv
// Shared definitions for the N-way round-robin / fixed-priority arbiter.
//   MODE_FIXED / MODE_RR : values of the MODE input
//   arb_state_e          : arbiter state (IDLE = no grant, BUSY = one grant held)
package rr_arb_defs;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational winner selection for the arbiter.
// Ports:
//   req    in  N     request vector
//   mask   in  N     requesters excluded from this search
//   start  in  ID_W  round-robin search origin (ignored in fixed mode)
//   mode   in  1     MODE_FIXED: lowest index wins; MODE_RR: first set bit
//                    searching upward from start with wrap-around
//   onehot out N     one-hot winner, zero when none
//   id     out ID_W  winner index, zero when none
//   any    out 1     a winner exists
module rr_arb_pick
  import rr_arb_defs::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] start,
  input  logic            mode,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] id,
  output logic            any
);

  logic [N-1:0] eff;

  assign eff = req & ~mask;

  always_comb begin
    int unsigned base;
    int unsigned idx;
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    idx    = 0;
    // Fixed priority is a round-robin search that always starts at index 0.
    base   = (mode == MODE_RR) ? int'(start) : 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (!any && eff[idx]) begin
        any         = 1'b1;
        onehot[idx] = 1'b1;
        id          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with registered one-hot grant, runtime-selectable
// fixed-priority or round-robin mode, and grant locking while the owner
// keeps requesting.
// Optional feature macro: RR_ARB_HOLD_LIMIT_EN -- when defined, an owner
// that has held the grant for MAX_HOLD cycles is forced to yield if any
// other requester is waiting.
// Ports:
//   clk        in  1     clock, rising edge
//   reset      in  1     synchronous active-high reset
//   REQ        in  N     request vector
//   MODE       in  1     0 = fixed priority (bit 0 highest), 1 = round-robin
//   GNT        out N     registered one-hot grant or zero
//   GNT_VALID  out 1     registered, equals |GNT
//   GNT_ID     out ID_W  registered index of granted requester, 0 when idle
module rr_priority_arbiter
  import rr_arb_defs::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    REQ,
  input  logic            MODE,
  output logic [N-1:0]    GNT,
  output logic            GNT_VALID,
  output logic [ID_W-1:0] GNT_ID
);

  if (N < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_priority_arbiter: requires N >= 2 and MAX_HOLD >= 1");
  end

  arb_state_e      state_q, state_nxt;
  logic [N-1:0]    gnt_q, gnt_nxt;
  logic [ID_W-1:0] id_q, id_nxt;
  logic [ID_W-1:0] ptr_q, ptr_nxt;

  logic            owner_req;
  logic            force_rot;
  logic [N-1:0]    pick_mask;
  logic [N-1:0]    pick_onehot;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;

  // gnt_q is one-hot or zero, so this is REQ[owner] without indexing.
  assign owner_req = |(REQ & gnt_q);

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             cnt_at_limit;

  assign cnt_at_limit = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign force_rot    = owner_req && cnt_at_limit && (|(REQ & ~gnt_q));
`else
  assign force_rot = 1'b0;
`endif

  // Forced rotation hides the still-requesting owner from the search; on a
  // normal release the owner's REQ bit is already 0, so no mask is needed.
  assign pick_mask = force_rot ? gnt_q : '0;

  rr_arb_pick #(.N(N)) u_pick (
    .req    (REQ),
    .mask   (pick_mask),
    .start  (ptr_q),
    .mode   (MODE),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    logic take;
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    ptr_nxt   = ptr_q;
    take      = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
    cnt_nxt   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: take = 1'b1;
      ST_BUSY: begin
        if (owner_req && !force_rot) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (!cnt_at_limit) begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
`endif
        end else begin
          take = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
      end
    endcase

    if (take) begin
      if (pick_any) begin
        state_nxt = ST_BUSY;
        gnt_nxt   = pick_onehot;
        id_nxt    = pick_id;
        ptr_nxt   = (pick_id == ID_W'(N - 1)) ? '0 : pick_id + ID_W'(1);
`ifdef RR_ARB_HOLD_LIMIT_EN
        cnt_nxt   = '0;
`endif
      end else begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      id_q    <= id_nxt;
      ptr_q   <= ptr_nxt;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_nxt;
`endif
    end
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = (state_q == ST_BUSY);
  assign GNT_ID    = id_q;

endmodule
